useq_controller: RTL and testbench
==================================

Name: useq_controller

Overview:
Parametrised microprogram sequencer: the next-generation control unit for the matrix-multiply cores. It holds the micro-PC and drives the address of an external, combinational-read microcode ROM. Each micro-instruction selects its successor: increment, jump, conditional jump, IR map, call, return or halt. It adds a start/done handshake, a stall input, selectable condition flags and a return-address stack, so shared microroutines such as the MAC loop and memory write-back can be reused.

Parameters:
ADDR_W, 16, micro-address width
OP_W, 51, control-signal word width
IR_W, 8, instruction register width
MAP_SHIFT, 3, IR-to-address left shift (8 words per opcode)
NCOND, 4, number of condition flags; CS_W = max(1, clog2(NCOND))
STACK_DEPTH, 4, return-stack entries (>=1)
FETCH_ADDR, 0, micro-address loaded on start

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  start request, sampled in IDLE only
stall  in  1  hold micro-PC and suppress ops (datapath/memory not ready)
ir  in  IR_W  current instruction register
flags  in  NCOND  datapath condition flags (bit 0 = z)
uaddr  out  ADDR_W  micro-PC, ROM address (registered)
u_seq  in  3  ROM field: sequencing opcode
u_csel  in  CS_W  ROM field: condition select
u_cpol  in  1  ROM field: invert condition
u_jaddr  in  ADDR_W  ROM field: jump/call target
u_ops  in  OP_W  ROM field: control signals
ops  out  OP_W  control signals to datapath
busy  out  1  high in RUN
done  out  1  one-cycle pulse on normal halt
err  out  1  sticky stack overflow/underflow flag

Behaviour:
- Reset (async, reset=0): state=IDLE, uPC=FETCH_ADDR, stack pointer=0, done=0, err=0. ops=0, busy=0.
- States: IDLE, RUN.
- IDLE: ops=0. On start=1, load uPC=FETCH_ADDR, clear err, go to RUN. stall is ignored in IDLE.
- RUN: busy=1. ops=u_ops when stall=0, else ops=0. Output ops is combinational from the ROM word at uaddr.
- Latency: first micro-instruction ops are valid the cycle after start is sampled.
- stall=1 in RUN: uPC, stack and state hold; no sequencing action is taken.
- Sequencing (stall=0), next uPC:
  - NEXT(0): uPC+1, wrapping mod 2^ADDR_W.
  - JUMP(1): u_jaddr.
  - CJUMP(2): if (flags[u_csel]^u_cpol) then u_jaddr, else uPC+1. A u_csel >= NCOND reads as 0.
  - MAP(3): (ir << MAP_SHIFT) truncated to ADDR_W.
  - CALL(4): push uPC+1, then uPC=u_jaddr.
  - RET(5): pop into uPC.
  - HALT(6): done=1 for exactly one cycle (registered), uPC=FETCH_ADDR, state=IDLE.
  - Code 7 is reserved and behaves as NEXT.
- Stack: LIFO of STACK_DEPTH entries, ADDR_W wide.
  - CALL when full: no push, err=1, go to IDLE, done stays 0.
  - RET when empty: err=1, go to IDLE.
- start asserted while in RUN is ignored.
- err holds until the next accepted start or reset.
- Reset mid-run aborts immediately to the reset values; stack contents are don't-care, pointer=0.
- A HALT word's ops are still driven during the cycle it is at uaddr.

Decomposition:
- Package ctrl_seq_pkg: sequencing opcode constants SEQ_NEXT..SEQ_HALT and the 3-bit field width.
- Sub-module useq_stack (push, pop, full, empty, data; async active-low reset) holds the return addresses.
- The top level contains the state register, uPC register and next-address mux.

Test Plan:
- Reset, then start with a ROM of NEXT at 0..2 and HALT at 3 -> uaddr sequence 0,1,2,3; busy high for 4 cycles; done pulses once the cycle after addr 3; ops matches u_ops at each step.
- ir=5, MAP_SHIFT=3, MAP at addr 1 -> next uaddr=40. With ir=0xFF and ADDR_W=10 -> uaddr=0x3F8 truncated correctly.
- CJUMP u_csel=0, u_cpol=0, target 0x20: z=1 -> 0x20; z=0 -> pc+1. Repeat with u_cpol=1 -> outcomes inverted.
- Nested CALL at depths 1..4 to 0x10/0x20/0x30/0x40, then 4 RETs -> returns to each call+1 in reverse order; a 5th CALL -> err=1, IDLE, done=0.
- Assert stall for 3 cycles mid-routine -> uaddr frozen, ops=0; on release, sequence resumes with no step skipped. RET at empty stack -> err=1.
- Deassert reset during RUN at addr 7 with stack depth 2 -> immediately IDLE, uaddr=FETCH_ADDR, ops=0. A new start runs cleanly with an empty stack.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_seq_pkg
// Shared definitions for the microprogram sequencer:
//   - SEQ_W     : width of the micro-instruction sequencing field
//   - seq_op_e  : sequencing opcodes (successor selection)
//   - state_e   : sequencer control states
//   - cs_width  : condition-select field width for a given flag count
// No ports (package).
// -----------------------------------------------------------------------------
package ctrl_seq_pkg;

  localparam int SEQ_W = 3;

  typedef enum logic [SEQ_W-1:0] {
    SEQ_NEXT  = 3'd0,
    SEQ_JUMP  = 3'd1,
    SEQ_CJUMP = 3'd2,
    SEQ_MAP   = 3'd3,
    SEQ_CALL  = 3'd4,
    SEQ_RET   = 3'd5,
    SEQ_HALT  = 3'd6,
    SEQ_RSVD  = 3'd7   // decoded exactly like SEQ_NEXT
  } seq_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // A single flag still needs a 1-bit select field.
  function automatic int cs_width(input int ncond);
    return (ncond > 1) ? $clog2(ncond) : 1;
  endfunction

endpackage

// File: rtl/useq_stack.sv
// -----------------------------------------------------------------------------
// useq_stack
// Return-address LIFO for the microprogram sequencer.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-low reset (pointer only)
//   clr    in   empty the stack (synchronous)
//   push   in   push din (ignored when full)
//   pop    in   drop top entry (ignored when empty)
//   din    in   WIDTH  data to push
//   dout   out  WIDTH  current top entry (0 when empty)
//   full   out  DEPTH entries held
//   empty  out  no entries held
// -----------------------------------------------------------------------------
module useq_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] sp_q;
  logic [PTR_W-1:0] sp_d;
  logic             do_push;

  assign full    = (sp_q == PTR_W'(DEPTH));
  assign empty   = (sp_q == '0);
  assign do_push = push && !full && !clr;

  always_comb begin
    sp_d = sp_q;
    if (clr) begin
      sp_d = '0;
    end else if (do_push) begin
      sp_d = sp_q + PTR_W'(1);
    end else if (pop && !empty) begin
      sp_d = sp_q - PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entry storage carries no reset: contents are meaningless once the
  // pointer is cleared, and leaving it out keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[IDX_W'(sp_q)] <= din;
    end
  end

  // Guard the empty case so the read index never leaves the array.
  always_comb begin
    dout = '0;
    if (!empty) begin
      dout = mem_q[IDX_W'(sp_q - PTR_W'(1))];
    end
  end

endmodule

// File: rtl/useq_controller.sv
// -----------------------------------------------------------------------------
// useq_controller
// Microprogram sequencer: holds the micro-PC, addresses an external
// combinational-read microcode ROM and selects each successor address.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset
//   start    in   start request (sampled in IDLE only)
//   stall    in   freeze sequencing and blank ops while running
//   ir       in   IR_W    instruction register (MAP source)
//   flags    in   NCOND   datapath condition flags (bit 0 = z)
//   uaddr    out  ADDR_W  registered micro-PC / ROM address
//   u_seq    in   3       ROM: sequencing opcode
//   u_csel   in   CS_W    ROM: condition select
//   u_cpol   in   1       ROM: invert condition
//   u_jaddr  in   ADDR_W  ROM: jump/call target
//   u_ops    in   OP_W    ROM: control word
//   ops      out  OP_W    control word to datapath
//   busy     out  high while running
//   done     out  one-cycle pulse after a normal HALT
//   err      out  sticky stack overflow/underflow
// -----------------------------------------------------------------------------
module useq_controller
  import ctrl_seq_pkg::*;
#(
  parameter int  ADDR_W      = 16,
  parameter int  OP_W        = 51,
  parameter int  IR_W        = 8,
  parameter int  MAP_SHIFT   = 3,
  parameter int  NCOND       = 4,
  parameter int  STACK_DEPTH = 4,
  parameter int  FETCH_ADDR  = 0,
  localparam int CS_W        = cs_width(NCOND)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic [IR_W-1:0]   ir,
  input  logic [NCOND-1:0]  flags,
  output logic [ADDR_W-1:0] uaddr,
  input  logic [SEQ_W-1:0]  u_seq,
  input  logic [CS_W-1:0]   u_csel,
  input  logic              u_cpol,
  input  logic [ADDR_W-1:0] u_jaddr,
  input  logic [OP_W-1:0]   u_ops,
  output logic [OP_W-1:0]   ops,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] FETCH = ADDR_W'(FETCH_ADDR);
  localparam int                MAP_W = ADDR_W + IR_W + MAP_SHIFT;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   upc_q, upc_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [ADDR_W-1:0]   upc_inc;
  logic [ADDR_W-1:0]   map_addr;
  logic [(1<<CS_W)-1:0] flags_ext;
  logic                cond;

  logic                stk_clr, stk_push, stk_pop;
  logic                stk_full, stk_empty;
  logic [ADDR_W-1:0]   stk_top;

  assign upc_inc  = upc_q + ADDR_W'(1);
  // Widen before shifting so no IR bits are lost, then keep the low bits.
  assign map_addr = ADDR_W'(MAP_W'(ir) << MAP_SHIFT);

  // Pad the flags out to every encodable select value; selects beyond
  // NCOND land on the zero padding.
  always_comb begin
    flags_ext              = '0;
    flags_ext[NCOND-1:0]   = flags;
  end

  assign cond = flags_ext[u_csel] ^ u_cpol;

  useq_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .clr   (stk_clr),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (upc_inc),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    state_d  = state_q;
    upc_d    = upc_q;
    done_d   = 1'b0;
    err_d    = err_q;
    stk_clr  = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // A fresh run never inherits return addresses from an aborted one.
          state_d = ST_RUN;
          upc_d   = FETCH;
          err_d   = 1'b0;
          stk_clr = 1'b1;
        end
      end

      ST_RUN: begin
        if (!stall) begin
          case (seq_op_e'(u_seq))
            SEQ_JUMP:  upc_d = u_jaddr;
            SEQ_CJUMP: upc_d = cond ? u_jaddr : upc_inc;
            SEQ_MAP:   upc_d = map_addr;
            SEQ_CALL: begin
              if (stk_full) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
                upc_d   = FETCH;
              end else begin
                stk_push = 1'b1;
                upc_d    = u_jaddr;
              end
            end
            SEQ_RET: begin
              if (stk_empty) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
                upc_d   = FETCH;
              end else begin
                stk_pop = 1'b1;
                upc_d   = stk_top;
              end
            end
            SEQ_HALT: begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
              upc_d   = FETCH;
            end
            default: upc_d = upc_inc;  // NEXT and the reserved code
          endcase
        end
      end

      default: begin
        state_d = ST_IDLE;
        upc_d   = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      upc_q   <= FETCH;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign uaddr = upc_q;
  assign busy  = (state_q == ST_RUN);
  // Combinational from the ROM word so a word's controls appear in the
  // same cycle its address is presented, HALT words included.
  assign ops   = (busy && !stall) ? u_ops : '0;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_useq_controller.sv
module tb_useq_controller;

  localparam int AW   = 10;
  localparam int OW   = 51;
  localparam int IW   = 8;
  localparam int MS   = 3;
  localparam int NC   = 4;
  localparam int SD   = 4;
  localparam int FA   = 0;
  localparam int AMOD = 1 << AW;

  localparam logic [2:0] NXT = 3'd0, JMP = 3'd1, CJ = 3'd2, MAPO = 3'd3;
  localparam logic [2:0] CALL = 3'd4, RET = 3'd5, HALT = 3'd6, RSV = 3'd7;

  logic          clk, reset, start, stall;
  logic [IW-1:0] ir;
  logic [NC-1:0] flags;
  logic [AW-1:0] uaddr;
  logic [2:0]    u_seq;
  logic [1:0]    u_csel;
  logic          u_cpol;
  logic [AW-1:0] u_jaddr;
  logic [OW-1:0] u_ops, ops;
  logic          busy, done, err;

  // external microcode ROM, combinational read
  logic [2:0]    rom_seq   [AMOD];
  logic [1:0]    rom_csel  [AMOD];
  logic          rom_cpol  [AMOD];
  logic [AW-1:0] rom_jaddr [AMOD];
  logic [OW-1:0] rom_ops   [AMOD];

  assign u_seq   = rom_seq[uaddr];
  assign u_csel  = rom_csel[uaddr];
  assign u_cpol  = rom_cpol[uaddr];
  assign u_jaddr = rom_jaddr[uaddr];
  assign u_ops   = rom_ops[uaddr];

  useq_controller #(
    .ADDR_W(AW), .OP_W(OW), .IR_W(IW), .MAP_SHIFT(MS),
    .NCOND(NC), .STACK_DEPTH(SD), .FETCH_ADDR(FA)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .ir(ir),
    .flags(flags), .uaddr(uaddr), .u_seq(u_seq), .u_csel(u_csel),
    .u_cpol(u_cpol), .u_jaddr(u_jaddr), .u_ops(u_ops), .ops(ops),
    .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int busy_cnt, done_cnt;
  int trace[$];

  // reference model state
  bit m_run, m_done, m_err;
  int m_pc;
  int m_stk[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run  = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_pc   = FA;
    m_stk.delete();
  endfunction

  function automatic void model_abort();
    m_err = 1'b1;
    m_run = 1'b0;
    m_pc  = FA;
  endfunction

  // one clock edge of the sequencer, from the rules
  function automatic void model_edge();
    bit c;
    m_done = 1'b0;
    if (!reset) begin
      model_reset();
      return;
    end
    if (!m_run) begin
      if (start) begin
        m_run = 1'b1;
        m_pc  = FA;
        m_err = 1'b0;
        m_stk.delete();
      end
      return;
    end
    if (stall) return;
    case (rom_seq[m_pc])
      JMP:  m_pc = int'(rom_jaddr[m_pc]);
      CJ: begin
        c = flags[rom_csel[m_pc]] ^ rom_cpol[m_pc];
        m_pc = c ? int'(rom_jaddr[m_pc]) : (m_pc + 1) % AMOD;
      end
      MAPO: m_pc = (int'(ir) * (1 << MS)) % AMOD;
      CALL: begin
        if (m_stk.size() == SD) model_abort();
        else begin
          m_stk.push_back((m_pc + 1) % AMOD);
          m_pc = int'(rom_jaddr[m_pc]);
        end
      end
      RET: begin
        if (m_stk.size() == 0) model_abort();
        else m_pc = m_stk.pop_back();
      end
      HALT: begin
        m_done = 1'b1;
        m_run  = 1'b0;
        m_pc   = FA;
      end
      default: m_pc = (m_pc + 1) % AMOD;
    endcase
  endfunction

  task automatic check_outputs();
    logic [OW-1:0] e_ops;
    e_ops = (m_run && !stall) ? rom_ops[m_pc] : '0;
    chk("uaddr", uaddr, m_pc);
    chk("busy", busy, m_run);
    chk("done", done, m_done);
    chk("err", err, m_err);
    chk("ops", ops, e_ops);
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
    trace.push_back(int'(uaddr));
  endtask

  // called at a falling edge with inputs already driven
  task automatic cyc();
    if (!reset) model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic run_idle(input int max);
    int n;
    n = 0;
    while (busy === 1'b1 && n < max) begin
      cyc();
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  function automatic void rom_fill_halt();
    for (int a = 0; a < AMOD; a++) begin
      rom_seq[a]   = HALT;
      rom_csel[a]  = 2'd0;
      rom_cpol[a]  = 1'b0;
      rom_jaddr[a] = '0;
      rom_ops[a]   = OW'({$urandom(), $urandom()});
    end
  endfunction

  function automatic void rom_set(input int a, input logic [2:0] s, input int j,
                                  input int cs = 0, input bit cp = 1'b0);
    rom_seq[a]   = s;
    rom_jaddr[a] = AW'(j);
    rom_csel[a]  = 2'(cs);
    rom_cpol[a]  = cp;
  endfunction

  typedef struct {
    logic [AW-1:0] at;
    logic [2:0]    seq;
    logic [1:0]    csel;
    logic          cpol;
    logic [AW-1:0] jaddr;
    logic [NC-1:0] flg;
    logic [IW-1:0] irv;
    logic [AW-1:0] exp_next;
  } vec_t;

  vec_t vt [15];
  int   exp_nest [10];
  int   exp_stall [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{10'h100, NXT,  2'd0, 1'b0, 10'h000, 4'h0, 8'h00, 10'h101};
    vt[1]  = '{10'h100, JMP,  2'd0, 1'b0, 10'h2A5, 4'h0, 8'h00, 10'h2A5};
    vt[2]  = '{10'h100, CJ,   2'd0, 1'b0, 10'h020, 4'h1, 8'h00, 10'h020};
    vt[3]  = '{10'h100, CJ,   2'd0, 1'b0, 10'h020, 4'h0, 8'h00, 10'h101};
    vt[4]  = '{10'h100, CJ,   2'd0, 1'b1, 10'h020, 4'h1, 8'h00, 10'h101};
    vt[5]  = '{10'h100, CJ,   2'd0, 1'b1, 10'h020, 4'h0, 8'h00, 10'h020};
    vt[6]  = '{10'h100, CJ,   2'd3, 1'b0, 10'h020, 4'h8, 8'h00, 10'h020};
    vt[7]  = '{10'h100, CJ,   2'd2, 1'b0, 10'h020, 4'hB, 8'h00, 10'h101};
    vt[8]  = '{10'h100, MAPO, 2'd0, 1'b0, 10'h000, 4'h0, 8'h05, 10'h028};
    vt[9]  = '{10'h100, MAPO, 2'd0, 1'b0, 10'h000, 4'h0, 8'hFF, 10'h3F8};
    vt[10] = '{10'h100, CALL, 2'd0, 1'b0, 10'h033, 4'h0, 8'h00, 10'h033};
    vt[11] = '{10'h100, RSV,  2'd0, 1'b0, 10'h3C0, 4'h0, 8'h00, 10'h101};
    vt[12] = '{10'h3FF, NXT,  2'd0, 1'b0, 10'h000, 4'h0, 8'h00, 10'h000};
    vt[13] = '{10'h200, HALT, 2'd0, 1'b0, 10'h155, 4'h0, 8'h00, 10'h000};
    vt[14] = '{10'h100, CJ,   2'd1, 1'b1, 10'h020, 4'h2, 8'h00, 10'h101};
    exp_nest  = '{0, 'h0, 'h10, 'h20, 'h30, 'h40, 'h31, 'h21, 'h11, 'h1};
    exp_stall = '{2, 3, 4, 5, 6};

    reset = 1'b0; start = 1'b0; stall = 1'b0; ir = '0; flags = '0;
    busy_cnt = 0; done_cnt = 0;
    rom_fill_halt();
    model_reset();
    @(negedge clk);

    // reset values, with stall and start held to show they do nothing
    stall = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    stall = 1'b0;
    reset = 1'b1;
    cyc();

    // straight-line program ending in HALT
    rom_fill_halt();
    for (int a = 0; a < 3; a++) rom_set(a, NXT, 0);
    trace.delete(); busy_cnt = 0; done_cnt = 0;
    pulse_start();
    for (int i = 0; i < 6; i++) cyc();
    chk("basic_busy_cycles", busy_cnt, 4);
    chk("basic_done_pulses", done_cnt, 1);
    for (int i = 0; i < 4; i++) chk("basic_trace", trace[i + 1], i);
    chk("basic_done_slot", trace[5], FA);
    $display("basic: busy=%0d done=%0d", busy_cnt, done_cnt);

    // single-instruction successor table
    for (int i = 0; i < 15; i++) begin
      rom_fill_halt();
      rom_set(0, JMP, int'(vt[i].at));
      rom_set(int'(vt[i].at), vt[i].seq, int'(vt[i].jaddr), int'(vt[i].csel), vt[i].cpol);
      flags = vt[i].flg;
      ir    = vt[i].irv;
      pulse_start();
      cyc();
      cyc();
      chk("vec_next", uaddr, vt[i].exp_next);
      $display("vec %0d: seq=%0d at=%h -> uaddr=%h", i, vt[i].seq, vt[i].at, uaddr);
      do_reset();
    end
    flags = '0; ir = '0;

    // nested calls to full depth, then unwind
    rom_fill_halt();
    rom_set(0, CALL, 'h10);
    rom_set('h10, CALL, 'h20);
    rom_set('h20, CALL, 'h30);
    rom_set('h30, CALL, 'h40);
    rom_set('h40, RET, 0);
    rom_set('h31, RET, 0);
    rom_set('h21, RET, 0);
    rom_set('h11, RET, 0);
    trace.delete();
    pulse_start();
    run_idle(30);
    chk("nest_len", trace.size(), 10);
    for (int i = 0; i < 10 && i < trace.size(); i++) chk("nest_trace", trace[i], exp_nest[i]);
    chk("nest_done", done, 1'b1);
    chk("nest_err", err, 1'b0);
    $display("nest: %0d steps", trace.size());

    // fifth call overflows
    rom_set('h40, CALL, 'h50);
    pulse_start();
    done_cnt = 0;
    run_idle(30);
    cyc();
    chk("ovf_err", err, 1'b1);
    chk("ovf_uaddr", uaddr, FA);
    chk("ovf_done", done_cnt, 0);
    $display("overflow: err=%0d", err);

    // stall in the middle of a straight run
    rom_fill_halt();
    for (int a = 0; a < 6; a++) rom_set(a, NXT, 0);
    pulse_start();
    cyc();
    cyc();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_uaddr", uaddr, 2);
      chk("stall_ops", ops, '0);
      cyc();
    end
    stall = 1'b0;
    trace.delete();
    run_idle(20);
    chk("stall_len", trace.size(), 5);
    for (int i = 0; i < 5 && i < trace.size(); i++) chk("stall_trace", trace[i], exp_stall[i]);
    $display("stall: resumed over %0d steps", trace.size());

    // return with nothing on the stack, then err clears on restart
    rom_fill_halt();
    rom_set(0, RET, 0);
    pulse_start();
    run_idle(5);
    chk("underflow_err", err, 1'b1);
    rom_set(0, HALT, 0);
    pulse_start();
    chk("err_clear", err, 1'b0);
    run_idle(5);
    $display("underflow: handled");

    // asynchronous reset mid-routine with two return addresses stacked
    rom_fill_halt();
    rom_set(0, CALL, 'h10);
    rom_set('h10, CALL, 5);
    for (int a = 5; a < 9; a++) rom_set(a, NXT, 0);
    pulse_start();
    begin
      int n;
      n = 0;
      while (uaddr !== AW'(7) && n < 10) begin
        cyc();
        n++;
      end
    end
    chk("reach7", uaddr, 7);
    reset = 1'b0;
    #1;
    model_reset();
    chk("arst_uaddr", uaddr, FA);
    chk("arst_busy", busy, 1'b0);
    chk("arst_ops", ops, '0);
    cyc();
    reset = 1'b1;
    rom_set(0, RET, 0);
    pulse_start();
    run_idle(5);
    chk("arst_stack_empty", err, 1'b1);
    $display("async reset: stack empty after restart");

    // randomized program and inputs against the model
    for (int a = 0; a < AMOD; a++) begin
      int r;
      logic [2:0] s;
      r = $urandom_range(0, 99);
      if (r < 30) s = NXT;
      else if (r < 45) s = JMP;
      else if (r < 65) s = CJ;
      else if (r < 70) s = MAPO;
      else if (r < 80) s = CALL;
      else if (r < 90) s = RET;
      else if (r < 95) s = HALT;
      else s = RSV;
      rom_set(a, s, $urandom_range(0, AMOD - 1), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      rom_ops[a] = OW'({$urandom(), $urandom()});
    end
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      stall = ($urandom_range(0, 4) == 0);
      flags = NC'($urandom());
      if ($urandom_range(0, 7) == 0) ir = IW'($urandom());
      reset = ($urandom_range(0, 199) != 0);
      cyc();
    end
    reset = 1'b1; start = 1'b0; stall = 1'b0;
    cyc();
    $display("random: done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
